jtag_tap_generic: RTL

- IEEE 1149.1 TAP controller for non-FPGA builds.
- Drives the same user-chain strobes (CAPTURE, SHIFT, UPDATE, SEL, …) that the FPGA boundary-scan primitive provides, so the same user data register works in both builds.
- Sits between the chip JTAG pins and the debug user register.
- Implements the 16-state TAP FSM, an instruction register with IDCODE, BYPASS and one USER opcode, and the TDO output mux.

---
 rtl/jtag_tap_generic.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_generic.sv
// IEEE 1149.1 TAP controller for non-FPGA builds. It presents the same
// user-chain strobes (CAPTURE/SHIFT/UPDATE/SEL/DRCK...) as the FPGA
// boundary-scan primitive, so one user data register serves both builds.
// Contents: the 16-state TAP FSM, an IR with IDCODE/BYPASS/USER decode,
// and the falling-edge TDO output stage.
module jtag_tap_generic #(
    parameter int                IR_LEN        = 6,
    parameter logic [IR_LEN-1:0] USER_OPCODE   = IR_LEN'('h02),
    parameter logic [IR_LEN-1:0] IDCODE_OPCODE = IR_LEN'('h09),
    parameter logic [31:0]       IDCODE_VALUE  = 32'h0000_0001
) (
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_oe,
    output logic CAPTURE,
    output logic DRCK,
    output logic RESET,
    output logic RUNTEST,
    output logic SEL,
    output logic SHIFT,
    output logic TCK,
    output logic TDI,
    output logic TMS,
    output logic UPDATE,
    input  logic TDO
);

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAUSE_DR, ST_EX2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR
    } tap_state_e;

    tap_state_e        state_q, state_d;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0] ir_q, ir_d;
    logic              bypass_q, bypass_d;
    logic [31:0]       idcode_q, idcode_d;
    logic              tdo_q, tdo_d;
    logic              tdo_oe_q, tdo_oe_d;

    logic              sel_user;
    logic              sel_idcode;
    logic              dr_tdo;

    // Instruction decode; anything unrecognised (incl. all-ones) is BYPASS.
    assign sel_user   = (ir_q == USER_OPCODE);
    assign sel_idcode = (ir_q == IDCODE_OPCODE);
    assign dr_tdo     = sel_user ? TDO : (sel_idcode ? idcode_q[0] : bypass_q);

    // State strobes decoded straight from the state register.
    assign CAPTURE = (state_q == ST_CAP_DR);
    assign SHIFT   = (state_q == ST_SH_DR);
    assign UPDATE  = (state_q == ST_UPD_DR);
    assign RESET   = (state_q == ST_TLR);
    assign RUNTEST = (state_q == ST_RTI);
    assign SEL     = sel_user;

    // Pass-through copies of the pins, and the gated user-chain clock.
    assign TCK    = tck;
    assign TDI    = tdi;
    assign TMS    = tms;
    assign DRCK   = (sel_user && (CAPTURE || SHIFT)) ? tck : 1'b1;
    assign tdo    = tdo_q;
    assign tdo_oe = tdo_oe_q;

    // Next-state logic: standard TMS-driven TAP transition table.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_d = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    state_d = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = tms ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   state_d = tms ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_d = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    state_d = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = tms ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   state_d = tms ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    // Rising-edge shift paths: IR shift stage and the internal DRs.
    // Both DRs capture/shift every DR scan; the TDO mux picks the live one.
    always_comb begin
        ir_shift_d = ir_shift_q;
        bypass_d   = bypass_q;
        idcode_d   = idcode_q;
        case (state_q)
            ST_CAP_IR: ir_shift_d = IR_LEN'(2'b01);
            ST_SH_IR:  ir_shift_d = {tdi, ir_shift_q[IR_LEN-1:1]};
            ST_CAP_DR: begin
                bypass_d = 1'b0;
                idcode_d = IDCODE_VALUE;
            end
            ST_SH_DR: begin
                bypass_d = tdi;
                idcode_d = {tdi, idcode_q[31:1]};
            end
            default: ;
        endcase
    end

    // Falling-edge stage: IR update/reset and the TDO output register.
    // Outside the shift states tdo holds its last value with the driver off.
    always_comb begin
        ir_d     = ir_q;
        tdo_d    = tdo_q;
        tdo_oe_d = 1'b0;
        case (state_q)
            ST_TLR:    ir_d = IDCODE_OPCODE;
            ST_UPD_IR: ir_d = ir_shift_q;
            ST_SH_IR: begin
                tdo_d    = ir_shift_q[0];
                tdo_oe_d = 1'b1;
            end
            ST_SH_DR: begin
                tdo_d    = dr_tdo;
                tdo_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Rising-edge registers: FSM state and shift stages.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q    <= ST_TLR;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            idcode_q   <= '0;
        end else begin
            state_q    <= state_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    // Falling-edge registers: instruction register and TDO driver.
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_q     <= IDCODE_OPCODE;
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

endmodule
